// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// One bit per cycle in CALC (shift-add multiply, restoring divide) on operand
// magnitudes; sign correction is folded into the result register write on
// DONE entry. Divide-by-zero and signed overflow bypass CALC.
// Optional: define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      ALUSel,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state, state_nxt;
    logic [2:0]          op_q;
    logic                neg_a_q, neg_b_q;
    logic [XLEN-1:0]     opnd_q;       // multiplicand (mul) or divisor (div)
    logic [2*XLEN-1:0]   acc_q, acc_nxt; // {hi, lo} product or {rem, quo}
    logic [4:0]          cnt_q;

    logic [2:0]          op_in;
    logic                accept, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
    logic [XLEN-1:0]     ma_in, mb_in, special_res;
    logic                div0, ovf, special, fast_in;
    logic [XLEN:0]       sum, shifted, diff;

    assign op_in    = ALUSel[4:2];
    assign accept   = (state == IDLE) && start && (ALUSel[1:0] == 2'b01);
    // MULHU, DIVU, REMU treat a as unsigned; MULHSU additionally treats b as unsigned
    assign a_sgn_in = (op_in != 3'b011) && (op_in != 3'b101) && (op_in != 3'b111);
    assign b_sgn_in = a_sgn_in && (op_in != 3'b010);
    assign a_neg_in = a_sgn_in & a[XLEN-1];
    assign b_neg_in = b_sgn_in & b[XLEN-1];
    assign ma_in    = a_neg_in ? -a : a;
    assign mb_in    = b_neg_in ? -b : b;

    assign div0        = op_in[2] && (b == '0);
    assign ovf         = op_in[2] && !op_in[0] && (a == MIN_NEG) && (b == '1);
    assign special     = div0 || ovf;
    assign special_res = div0 ? (op_in[1] ? a : '1) : (op_in[1] ? '0 : MIN_NEG);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] prod_fast;
    assign prod_fast = {{XLEN{1'b0}}, ma_in} * {{XLEN{1'b0}}, mb_in};
    assign fast_in   = !op_in[2];
`else
    assign fast_in   = 1'b0;
`endif

    // Apply sign and select the requested half / quotient / remainder.
    function automatic logic [XLEN-1:0] fixup(input logic [2:0] op, input logic na,
                                              input logic nb, input logic [2*XLEN-1:0] acc);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q, r;
        p = (na ^ nb) ? -acc : acc;
        q = (na ^ nb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        r = na ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (!op[2])
            fixup = (op[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
        else
            fixup = op[1] ? r : q;
    endfunction

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        sum     = '0;
        shifted = '0;
        diff    = '0;
        acc_nxt = acc_q;
        if (!op_q[2]) begin
            sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
            acc_nxt = {sum, acc_q[XLEN-1:1]};
        end else begin
            shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
            diff    = shifted - {1'b0, opnd_q};
            if (!diff[XLEN])
                acc_nxt = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else
                acc_nxt = {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and busy decode.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) state_nxt = (special || fast_in) ? DONE : CALC;
            end
            CALC:    if (cnt_q == 5'd31) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration registers and result/done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    op_q    <= op_in;
                    neg_a_q <= a_neg_in;
                    neg_b_q <= b_neg_in;
                    cnt_q   <= '0;
                    if (special) begin
                        result <= special_res;
                        done   <= 1'b1;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (fast_in) begin
                        result <= fixup(op_in, a_neg_in, b_neg_in, prod_fast);
                        done   <= 1'b1;
                    end
`endif
                    else begin
                        opnd_q <= op_in[2] ? mb_in : ma_in;
                        acc_q  <= {{XLEN{1'b0}}, (op_in[2] ? ma_in : mb_in)};
                    end
                end
                CALC: begin
                    acc_q <= acc_nxt;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result <= fixup(op_q, neg_a_q, neg_b_q, acc_nxt);
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
